regfile_xor_lvt: RTL and testbench
==================================

# regfile_xor_lvt

Two-write-port, multi-read-port integer register file for the Taiga core. It is built from two single-write banks plus an XOR live-value table (LVT) that records which bank holds the newest copy of each register. It is the write/producer side of the `sel_bank` / per-bank register-array state that the simulation bench decodes to reconstruct the architectural register file. It sits in the register-file-and-writeback block, fed by the commit ports and read by issue.

## Interface
Parameters:
- `READ_PORTS`, 2: number of combinational read ports.
- `XLEN`, 32: data width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `init_done` out 1: high once the zero-initialisation sweep has finished.
- `we` in [2]: write enable per commit port.
- `wr_addr` in [2][5]: destination register per port.
- `wr_data` in [2][XLEN]: write data per port.
- `rd_addr` in [READ_PORTS][5]: read addresses.
- `rd_data` out [READ_PORTS][XLEN]: read data.

## Operation
- Storage:
  - `bank[p]`, 32×XLEN, is written only by port p.
  - LVT `sel_bank[p]`, 32×1, is owned by port p.
- Read selection, per entry i: `sel_bank[0][i] ^ sel_bank[1][i]`. Value 0 selects bank 0; value 1 selects bank 1.
- Write by port 0 to rd: `bank[0][rd] <= wr_data[0]`; `sel_bank[0][rd] <= sel_bank[1][rd]`. The XOR becomes 0.
- Write by port 1 to rd: `bank[1][rd] <= wr_data[1]`; `sel_bank[1][rd] <= ~sel_bank[0][rd]`. The XOR becomes 1.
- Writes to x0 are discarded. Reads of x0 always return 0.
- Same-cycle writes by both ports to the same nonzero rd: port 1 wins. Port 0's bank write and LVT update are both suppressed, and the XOR resolves to 1.
- Same-cycle writes to different rd: both complete independently.
- FSM:
  - INIT:
    - 5-bit counter `init_idx` runs 0→31.
    - Each cycle writes 0 to `bank[0][init_idx]`.
    - `we` is ignored.
    - `rd_data` is forced to 0.
    - At `init_idx == 31`, transition to RUN.
  - RUN: normal operation, `init_done = 1`.
  - No other transitions.
- Reset (asynchronous, may occur at any time including mid-INIT or mid-write):
  - Outputs and state:
    - `sel_bank` clears to all 0.
    - `init_idx` clears to 0.
    - The FSM returns to INIT.
    - `init_done` goes to 0.
    - `rd_data` goes to 0 immediately.
  - Bank contents are not reset; they are overwritten by the INIT sweep.

## Timing
- Reads are combinational: `rd_data` reflects `rd_addr` and the registered state in the same cycle.
- A write is visible to reads from the cycle after its clock edge.
- INIT lasts exactly 32 cycles after `rst` deasserts. `init_done` rises on the 32nd rising edge.
- Writes presented while `init_done = 0` are lost. Issue must not commit before `init_done`.

## Configuration
- `REGFILE_WRITE_BYPASS_EN` defined: a read whose `rd_addr` matches an active write (`we` high, nonzero address) in the same cycle returns that `wr_data` combinationally. If both ports match, port 1's data is returned.
- Not defined: no forwarding. The read returns the pre-edge value; the new value appears one cycle later.
- In both cases, INIT forcing and the x0 = 0 rule take precedence.

## Structure
- In `taiga_types`:
  - `rf_addr_t` (logic [4:0]).
  - `rf_data_t` (logic [XLEN-1:0]).
  - FSM enum `rf_init_state_t` {RF_INIT, RF_RUN}.
  - Constants `RF_WRITE_PORTS = 2` and `RF_ENTRIES = 32`.
- Sub-module `regfile_bank`: one write port, READ_PORTS combinational read ports, no reset. It is instantiated twice in generate block `for2[p]` as `register_file_blocks`, with array `register_file`.
- `sel_bank` is a top-level signal named `sel_bank`, typed [2][32]. These names are part of the debug interface used by the bench.

## Test plan
- Reset then 32 idle cycles:
  - `init_done` rises exactly on cycle 32.
  - All reads return 0 throughout INIT and after.
- Port 0 writes x5 = 0xDEADBEEF, then port 1 writes x5 = 0x12345678:
  - Reads of x5 return 0xDEADBEEF and then 0x12345678.
  - `sel_bank[0][5] ^ sel_bank[1][5]` is 0 and then 1.
- Same cycle, port 0 writes x7 = 0xAAAA0000 and port 1 writes x7 = 0x5555FFFF:
  - x7 reads 0x5555FFFF.
  - `bank[0][7]` is unchanged.
- Either port writes x0 = 0xFFFFFFFF: x0 still reads 0.
- Assert `rst` mid-INIT at `init_idx = 17` and mid-RUN after writes:
  - `rd_data = 0` and `init_done = 0` immediately, without a clock edge.
  - After release, a full 32-cycle sweep runs and previously written registers read 0.
- Port 1 writes x9 = 0xCAFEF00D while reading x9 in the same cycle:
  - With `REGFILE_WRITE_BYPASS_EN`, the read returns 0xCAFEF00D in that cycle.
  - Without it, the read returns the old value and 0xCAFEF00D appears the next cycle.

Source files
------------

// File: rtl/regfile_xor_lvt_pkg.sv
// regfile_xor_lvt_pkg: shared register-file types and constants (package taiga_types).
package taiga_types;
   localparam int RF_XLEN = 32;
   localparam int RF_WRITE_PORTS = 2;
   localparam int RF_ENTRIES = 32;
   typedef logic [4:0] rf_addr_t;
   typedef logic [RF_XLEN-1:0] rf_data_t;
   typedef enum logic {RF_INIT, RF_RUN} rf_init_state_t;
endpackage

// File: rtl/regfile_xor_lvt_if.sv
// regfile_xor_lvt_if: commit write ports, issue read ports and init status of the register file.
interface regfile_xor_lvt_if #(
   parameter int READ_PORTS = 2,
   parameter int XLEN = 32
);
   logic init_done;
   logic we [2];
   taiga_types::rf_addr_t wr_addr [2];
   logic [XLEN-1:0] wr_data [2];
   taiga_types::rf_addr_t rd_addr [READ_PORTS];
   logic [XLEN-1:0] rd_data [READ_PORTS];
   modport master (output we, wr_addr, wr_data, rd_addr, input rd_data, init_done);
   modport slave (input we, wr_addr, wr_data, rd_addr, output rd_data, init_done);
endinterface

// File: rtl/regfile_xor_lvt_bank.sv
// regfile_bank: one-write, multi-read register bank without reset; contents come from the init sweep.
module regfile_bank
   import taiga_types::*;
#(
   parameter int READ_PORTS = 2,
   parameter int XLEN = 32
) (
   input logic clk,
   input logic we,
   input rf_addr_t wr_addr,
   input logic [XLEN-1:0] wr_data,
   input rf_addr_t rd_addr [READ_PORTS],
   output logic [XLEN-1:0] rd_data [READ_PORTS]
);
   logic [XLEN-1:0] register_file [RF_ENTRIES];
   // Single write port into the bank storage
   always_ff @(posedge clk)
      if (we) register_file[wr_addr] <= wr_data;
   for (genvar r = 0; r < READ_PORTS; r++) begin : rd
      assign rd_data[r] = register_file[rd_addr[r]];
   end
endmodule

// File: rtl/regfile_xor_lvt.sv
// regfile_xor_lvt: two-write-port register file built from two banks and an XOR live-value table.
// Optional: define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_xor_lvt
   import taiga_types::*;
#(
   parameter int READ_PORTS = 2,
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   regfile_xor_lvt_if.slave bus
);
   rf_init_state_t state, state_next;
   rf_addr_t init_idx;
   logic sel_bank [RF_WRITE_PORTS][RF_ENTRIES];
   logic run, same_rd;
   logic wen [RF_WRITE_PORTS];
   logic bank_we [RF_WRITE_PORTS];
   rf_addr_t bank_addr [RF_WRITE_PORTS];
   logic [XLEN-1:0] bank_data [RF_WRITE_PORTS];
   logic [XLEN-1:0] bank_rd [RF_WRITE_PORTS][READ_PORTS];

   assign run = state == RF_RUN;
   assign bus.init_done = run;
   assign same_rd = bus.we[0] && bus.we[1] && bus.wr_addr[0] == bus.wr_addr[1];
   assign wen[1] = run && bus.we[1] && bus.wr_addr[1] != '0;
   assign wen[0] = run && bus.we[0] && bus.wr_addr[0] != '0 && !same_rd;

   for (genvar p = 0; p < RF_WRITE_PORTS; p++) begin : for2
      assign bank_we[p] = (p == 0 && !run) || wen[p];
      assign bank_addr[p] = run ? bus.wr_addr[p] : init_idx;
      assign bank_data[p] = run ? bus.wr_data[p] : '0;
      regfile_bank #(.READ_PORTS(READ_PORTS), .XLEN(XLEN)) register_file_blocks (
         .clk(clk),
         .we(bank_we[p]),
         .wr_addr(bank_addr[p]),
         .wr_data(bank_data[p]),
         .rd_addr(bus.rd_addr),
         .rd_data(bank_rd[p])
      );
   end

   // State register and init sweep counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= RF_INIT;
         init_idx <= '0;
      end else begin
         state <= state_next;
         init_idx <= run ? init_idx : init_idx + 5'd1;
      end

   // Leave INIT once the last entry has been cleared
   always_comb begin
      state_next = state;
      if (state == RF_INIT && init_idx == 5'd31) state_next = RF_RUN;
   end

   // LVT update: port 0 makes the XOR 0, port 1 makes it 1
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int j = 0; j < RF_WRITE_PORTS; j++)
            for (int k = 0; k < RF_ENTRIES; k++) sel_bank[j][k] <= 1'b0;
      end else begin
         if (wen[0]) sel_bank[0][bus.wr_addr[0]] <= sel_bank[1][bus.wr_addr[0]];
         if (wen[1]) sel_bank[1][bus.wr_addr[1]] <= ~sel_bank[0][bus.wr_addr[1]];
      end

   // Read mux: LVT picks the bank, optional forwarding, then INIT and x0 force zero
   always_comb begin
      for (int r = 0; r < READ_PORTS; r++) begin
         bus.rd_data[r] = (sel_bank[0][bus.rd_addr[r]] ^ sel_bank[1][bus.rd_addr[r]]) ? bank_rd[1][r] : bank_rd[0][r];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (wen[0] && bus.wr_addr[0] == bus.rd_addr[r]) bus.rd_data[r] = bus.wr_data[0];
         if (wen[1] && bus.wr_addr[1] == bus.rd_addr[r]) bus.rd_data[r] = bus.wr_data[1];
`endif
         if (!run || bus.rd_addr[r] == '0) bus.rd_data[r] = '0;
      end
   end
endmodule

// File: tb/tb_regfile_xor_lvt.sv
// tb_regfile_xor_lvt: directed table, random traffic against an array model, and reset corner cases.
module tb_regfile_xor_lvt;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] mdl [32];
   logic mdl_run = 1'b0;

   typedef struct {
      logic we0, we1;
      logic [4:0] a0, a1;
      logic [31:0] d0, d1;
      logic [4:0] ra0, ra1;
      logic [31:0] e0, e1;
      logic [4:0] la;
      logic lx;
   } vec_t;
   vec_t tbl [7];

   regfile_xor_lvt_if #(.READ_PORTS(2), .XLEN(32)) bus ();
   regfile_xor_lvt #(.READ_PORTS(2), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we0, input logic we1, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] ra0, input logic [4:0] ra1);
      bus.we[0] = we0; bus.we[1] = we1;
      bus.wr_addr[0] = a0; bus.wr_addr[1] = a1;
      bus.wr_data[0] = d0; bus.wr_data[1] = d1;
      bus.rd_addr[0] = ra0; bus.rd_addr[1] = ra1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
   endtask

   // Architectural effect of one cycle: port 1 wins a same-register collision, x0 never changes.
   task automatic tick();
      if (mdl_run) begin
         if (bus.we[1] && bus.wr_addr[1] != 0) mdl[bus.wr_addr[1]] = bus.wr_data[1];
         if (bus.we[0] && bus.wr_addr[0] != 0 && !(bus.we[1] && bus.wr_addr[1] == bus.wr_addr[0]))
            mdl[bus.wr_addr[0]] = bus.wr_data[0];
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      logic [31:0] v;
      v = mdl[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (bus.we[0] && bus.wr_addr[0] == ra) v = bus.wr_data[0];
      if (bus.we[1] && bus.wr_addr[1] == ra) v = bus.wr_data[1];
`endif
      return (ra == 0 || !mdl_run) ? 32'h0 : v;
   endfunction

   task automatic sweep(output int edges);
      edges = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         edges = k;
         if (bus.init_done) break;
         check("init_rd_zero", bus.rd_data[0], 32'h0);
      end
   endtask

   initial begin
      int edges;
      logic [31:0] old9;
      tbl[0] = '{1, 0, 5, 0, 32'hDEADBEEF, 0, 5, 0, 32'hDEADBEEF, 0, 5, 0};
      tbl[1] = '{0, 1, 0, 5, 0, 32'h12345678, 5, 0, 32'h12345678, 0, 5, 1};
      tbl[2] = '{1, 1, 7, 7, 32'hAAAA0000, 32'h5555FFFF, 7, 5, 32'h5555FFFF, 32'h12345678, 7, 1};
      tbl[3] = '{1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 0, 32'h12345678, 5, 1};
      tbl[4] = '{0, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 7, 0, 32'h5555FFFF, 7, 1};
      tbl[5] = '{1, 1, 3, 4, 32'h11111111, 32'h22222222, 3, 4, 32'h11111111, 32'h22222222, 4, 1};
      tbl[6] = '{1, 0, 4, 0, 32'h33333333, 0, 4, 3, 32'h33333333, 32'h11111111, 4, 0};
      clear_model();
      drive(0, 0, 0, 0, 0, 0, 5, 0);
      #1;
      check("reset_init_done", 32'(bus.init_done), 0);
      check("reset_rd", bus.rd_data[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sweep(edges);
      check("init_cycles", edges, 32);
      check("init_done", 32'(bus.init_done), 1);
      mdl_run = 1'b1;
      check("post_init_x5", bus.rd_data[0], 0);

      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].we0, tbl[i].we1, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].ra0, tbl[i].ra1);
         tick();
         drive(0, 0, 0, 0, 0, 0, tbl[i].ra0, tbl[i].ra1);
         #1;
         check($sformatf("tbl%0d_rd0", i), bus.rd_data[0], tbl[i].e0);
         check($sformatf("tbl%0d_rd1", i), bus.rd_data[1], tbl[i].e1);
         check($sformatf("tbl%0d_lvt", i), 32'(dut.sel_bank[0][tbl[i].la] ^ dut.sel_bank[1][tbl[i].la]), 32'(tbl[i].lx));
      end
      check("bank0_x7_kept", dut.for2[0].register_file_blocks.register_file[7], 0);

      drive(1, 0, 9, 0, 32'h0BAD0000, 0, 9, 0);
      tick();
      drive(0, 1, 0, 9, 0, 32'hCAFEF00D, 9, 0);
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      check("same_cycle_x9", bus.rd_data[0], 32'hCAFEF00D);
`else
      check("same_cycle_x9", bus.rd_data[0], 32'h0BAD0000);
`endif
      tick();
      drive(0, 0, 0, 0, 0, 0, 9, 0);
      #1;
      check("next_cycle_x9", bus.rd_data[0], 32'hCAFEF00D);

      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         #1;
         check("rand_rd0", bus.rd_data[0], exp_rd(bus.rd_addr[0]));
         check("rand_rd1", bus.rd_data[1], exp_rd(bus.rd_addr[1]));
         tick();
      end

      drive(0, 1, 0, 6, 0, 32'hFEEDFACE, 6, 9);
      tick();
      drive(0, 0, 0, 0, 0, 0, 6, 9);
      old9 = mdl[9];
      #1;
      check("pre_rst_x6", bus.rd_data[0], 32'hFEEDFACE);
      check("pre_rst_x9", bus.rd_data[1], old9);
      rst = 1'b1;
      #1;
      check("async_rst_rd0", bus.rd_data[0], 0);
      check("async_rst_rd1", bus.rd_data[1], 0);
      check("async_rst_done", 32'(bus.init_done), 0);
      clear_model();
      mdl_run = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sweep(edges);
      check("reinit_cycles", edges, 32);
      mdl_run = 1'b1;
      check("reinit_x6", bus.rd_data[0], 0);
      check("reinit_x9", bus.rd_data[1], 0);

      rst = 1'b1;
      mdl_run = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      check("mid_init_idx", 32'(dut.init_idx), 17);
      rst = 1'b1;
      #1;
      check("mid_init_idx_rst", 32'(dut.init_idx), 0);
      check("mid_init_done", 32'(bus.init_done), 0);
      check("mid_init_rd", bus.rd_data[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 1, 0, 6, 0, 32'hBAD0BAD0, 6, 9);
      sweep(edges);
      check("mid_init_cycles", edges, 32);
      drive(0, 0, 0, 0, 0, 0, 6, 9);
      mdl_run = 1'b1;
      #1;
      check("init_write_lost", bus.rd_data[0], 0);
      check("mid_init_x9", bus.rd_data[1], 0);
      drive(0, 1, 0, 5, 0, 32'h00000777, 5, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 5, 0);
      #1;
      check("alive_x5", bus.rd_data[0], 32'h00000777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
